// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding
// and the default 7-bit device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEVADDR  = 4'd1,
    ACK_DEV  = 4'd2,
    WORDADDR = 4'd3,
    ACK_WA   = 4'd4,
    WRDATA   = 4'd5,
    ACK_WR   = 4'd6,
    RDDATA   = 4'd7,
    MACK     = 4'd8
  } state_t;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h50;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for scl/sda, scl edge
// strobes and START/STOP condition detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  // synchronise the bus lines and keep one older sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign sda_s     = sda_ff[1];
  assign scl_rise  = ~scl_d & scl_ff[1];
  assign scl_fall  = scl_d & ~scl_ff[1];
  assign start_det = scl_d & scl_ff[1] & sda_d & ~sda_ff[1];
  assign stop_det  = scl_d & scl_ff[1] & ~sda_d & sda_ff[1];

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave with a 2**ADDR_W byte register memory.
// Define I2C_SLAVE_AUTO_INC_EN for pointer auto-increment.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef I2C_SLAVE_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t            st, st_n;
  logic [3:0]        cnt, cnt_n;
  logic [7:0]        sr, sr_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              sda_oe, oe_n;
  logic              busy_n;
  logic              we;
  logic [7:0]        nb;
  logic [7:0]        rd_byte;
  logic [7:0]        mem [DEPTH];

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign nb      = {sr[6:0], sda_s};
  assign rd_byte = mem[ptr];

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= 4'd0;
      sr     <= 8'h00;
      ptr    <= '0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      sr     <= sr_n;
      ptr    <= ptr_n;
      sda_oe <= oe_n;
      busy   <= busy_n;
    end
  end

  // next-state, shift and sda drive decisions
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    sr_n   = sr;
    ptr_n  = ptr;
    oe_n   = sda_oe;
    busy_n = busy;
    we     = 1'b0;
    unique case (1'b1)
      stop_det: begin
        st_n   = IDLE;
        cnt_n  = 4'd0;
        oe_n   = 1'b0;
        busy_n = 1'b0;
      end
      start_det: begin
        st_n   = DEVADDR;
        cnt_n  = 4'd0;
        oe_n   = 1'b0;
        busy_n = 1'b0;
      end
      default: begin
        unique case (st)
          IDLE: ;
          DEVADDR: begin
            if (scl_rise) begin
              sr_n  = nb;
              cnt_n = cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (nb[7:1] == DEV_ADDR) begin
                  busy_n = 1'b1;
                end else begin
                  st_n  = IDLE;
                  cnt_n = 4'd0;
                end
              end
            end else if (scl_fall && cnt == 4'd8) begin
              st_n  = ACK_DEV;
              cnt_n = 4'd0;
              oe_n  = 1'b1;
            end
          end
          ACK_DEV: begin
            if (scl_fall) begin
              if (sr[0]) begin
                st_n = RDDATA;
                sr_n = rd_byte;
                oe_n = ~rd_byte[7];
              end else begin
                st_n = WORDADDR;
                oe_n = 1'b0;
              end
            end
          end
          WORDADDR: begin
            if (scl_rise) begin
              sr_n  = nb;
              cnt_n = cnt + 4'd1;
              if (cnt == 4'd7) begin
                ptr_n = ADDR_W'(nb);
              end
            end else if (scl_fall && cnt == 4'd8) begin
              st_n  = ACK_WA;
              cnt_n = 4'd0;
              oe_n  = 1'b1;
            end
          end
          ACK_WA: begin
            if (scl_fall) begin
              st_n = WRDATA;
              oe_n = 1'b0;
            end
          end
          WRDATA: begin
            if (scl_rise) begin
              sr_n  = nb;
              cnt_n = cnt + 4'd1;
              if (cnt == 4'd7) begin
                we = 1'b1;
                if (AUTO_INC) begin
                  ptr_n = ptr + ADDR_W'(1);
                end
              end
            end else if (scl_fall && cnt == 4'd8) begin
              st_n  = ACK_WR;
              cnt_n = 4'd0;
              oe_n  = 1'b1;
            end
          end
          ACK_WR: begin
            if (scl_fall) begin
              st_n = WRDATA;
              oe_n = 1'b0;
            end
          end
          RDDATA: begin
            if (scl_rise) begin
              cnt_n = cnt + 4'd1;
              if (cnt == 4'd7 && AUTO_INC) begin
                ptr_n = ptr + ADDR_W'(1);
              end
            end else if (scl_fall) begin
              if (cnt == 4'd8) begin
                st_n  = MACK;
                cnt_n = 4'd0;
                oe_n  = 1'b0;
              end else begin
                sr_n = {sr[6:0], 1'b0};
                oe_n = ~sr[6];
              end
            end
          end
          MACK: begin
            if (scl_rise && sda_s) begin
              st_n   = IDLE;
              busy_n = 1'b0;
            end else if (scl_fall) begin
              st_n = RDDATA;
              sr_n = rd_byte;
              oe_n = ~rd_byte[7];
            end
          end
          default: st_n = IDLE;
        endcase
      end
    endcase
  end

  // commit strobe with its address and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= we;
      if (we) begin
        wr_addr <= ptr;
        wr_data <= nb;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    logic [7:0] b;
    // one memory byte, written when the pointer selects it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b <= 8'h00;
      end else if (we && ptr == ADDR_W'(g)) begin
        b <= nb;
      end
    end
    assign mem[g] = b;
  end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Randomised bench for i2c_slave_mem: bus-level master,
// array memory model and a write-strobe scoreboard.
module tb_i2c_slave_mem;

  localparam int Q = 6;
`ifdef I2C_SLAVE_AUTO_INC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_lo;
  wire        sda;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign sda = m_lo ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_mem #(
    .DEV_ADDR (7'h50),
    .ADDR_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] mon_e;
  logic [7:0]  ref_mem[256];
  logic [7:0]  mptr;
  logic [7:0]  dat[4];

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // scoreboard: every committed byte must be expected
  always @(negedge clk) begin
    if (!rst && wr_strobe) begin
      if (exp_wr.size() == 0) begin
        n_tot++;
        $display("FAIL wr_unexpected: got %h%h expected none",
                 wr_addr, wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_event", {wr_addr, wr_data}, mon_e);
      end
    end
  end

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bstart();
    m_lo = 1'b0; q();
    scl  = 1'b1; q();
    m_lo = 1'b1; q();
    scl  = 1'b0; q();
  endtask

  task automatic bstop();
    m_lo = 1'b1; q();
    scl  = 1'b1; q();
    m_lo = 1'b0; q();
  endtask

  task automatic wbit(input bit b);
    m_lo = ~b; q();
    scl  = 1'b1; q(); q();
    scl  = 1'b0; q();
  endtask

  task automatic rbit(output bit b);
    m_lo = 1'b0; q();
    scl  = 1'b1; q();
    b    = sda;  q();
    scl  = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output bit ack);
    bit a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    ack = ~a;
  endtask

  task automatic rbyte(output logic [7:0] d, input bit mack);
    bit b;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(~mack);
  endtask

  task automatic do_write(input logic [7:0] wa, input int n);
    bit ack;
    bstart();
    wbyte(8'hA0, ack); chk("ack_dev_w", 16'(ack), 16'd1);
    wbyte(wa, ack);    chk("ack_wa", 16'(ack), 16'd1);
    mptr = wa;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({mptr, dat[i]});
      ref_mem[mptr] = dat[i];
      if (AI) mptr++;
      wbyte(dat[i], ack);
      chk("ack_wr", 16'(ack), 16'd1);
    end
    bstop();
  endtask

  task automatic do_read(input logic [7:0] wa, input int n,
                         input bit use_wa);
    bit ack;
    logic [7:0] d;
    bstart();
    if (use_wa) begin
      wbyte(8'hA0, ack); chk("ack_dev_w", 16'(ack), 16'd1);
      wbyte(wa, ack);    chk("ack_wa", 16'(ack), 16'd1);
      mptr = wa;
      bstart();
    end
    wbyte(8'hA1, ack); chk("ack_dev_r", 16'(ack), 16'd1);
    chk("busy_rd", 16'(busy), 16'd1);
    for (int i = 0; i < n; i++) begin
      rbyte(d, i != n - 1);
      chk("rd_data", {mptr, d}, {mptr, ref_mem[mptr]});
      if (AI) mptr++;
    end
    bstop(); q();
    chk("busy_after_stop", 16'(busy), 16'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ack;
    int n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    mptr = 8'h00;
    rst = 1'b1; scl = 1'b1; m_lo = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sda", 16'(sda), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_wr_strobe", 16'(wr_strobe), 16'd0);
    chk("rst_wr_bus", {wr_addr, wr_data}, 16'h0000);

    dat[0] = 8'hAA;
    do_write(8'h55, 1);
    do_read(8'h55, 1, 1'b1);

    bstart();
    wbyte(8'hA2, ack);
    chk("nack_wrong_addr", 16'(ack), 16'd0);
    chk("busy_wrong_addr", 16'(busy), 16'd0);
    bstop(); q();
    do_read(8'h55, 1, 1'b1);

    bstart();
    wbyte(8'hA0, ack); chk("ack_dev_w", 16'(ack), 16'd1);
    wbyte(8'h10, ack); chk("ack_wa", 16'(ack), 16'd1);
    mptr = 8'h10;
    for (int i = 0; i < 4; i++) wbit(1'b1);
    bstop(); q();
    chk("busy_part_stop", 16'(busy), 16'd0);
    chk("sda_part_stop", 16'(sda), 16'd1);
    do_read(8'h10, 1, 1'b1);

    dat[0] = 8'h11; dat[1] = 8'h22;
    do_write(8'hFF, 2);
    do_read(8'hFF, 1, 1'b1);
    do_read(8'h00, 1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(8'($urandom), n);
        1: do_read(8'($urandom), n, 1'b1);
        default: do_read(8'h00, n, 1'b0);
      endcase
    end

    bstart();
    for (int i = 7; i >= 0; i--) wbit(i != 6 && i != 4 && i != 0 ? (i == 7 || i == 5) : 1'b0);
    m_lo = 1'b0; q();
    scl = 1'b1; q();
    chk("ack_before_rst", 16'(sda), 16'd0);
    rst = 1'b1;
    #1;
    chk("sda_on_rst", 16'(sda), 16'd1);
    chk("busy_on_rst", 16'(busy), 16'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    mptr = 8'h00;
    q();
    do_read(8'h55, 1, 1'b1);
    do_read(8'hFF, 2, 1'b1);
    do_read(8'h00, 1, 1'b0);

    repeat (20) @(negedge clk);
    chk("wr_pending", 16'(exp_wr.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
